// File: rtl/img_ram_loader_if.sv
// Byte-stream input and pixel-RAM write bus of the image loader.
// master = byte source / RAM side, slave = the loader itself.
interface img_ram_loader_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [7:0]            in_byte;
    logic                  in_valid;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [23:0]           wr_data;

    modport master (
        output in_byte, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_byte, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/img_ram_loader.sv
// Assembles an R,G,B byte stream into 24-bit pixels and writes IMG_PIXELS of them to RAM.
// Define IMG_LOADER_CHKSUM_EN to add the running 24-bit pixel checksum output.
module img_ram_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int IMG_PIXELS = 40000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    img_ram_loader_if.slave bus,
    output logic            busy,
`ifdef IMG_LOADER_CHKSUM_EN
    output logic [23:0]     chksum,
`endif
    output logic            done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(IMG_PIXELS - 1);

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0] pix_idx_q, pix_idx_d;
    logic [7:0]            r_q, r_d, g_q, g_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [23:0]           wr_data_q, wr_data_d;

    logic go, accept, pix_done, last_pix;

    assign go       = (state_q == S_IDLE) && start && !abort;
    assign accept   = bus.in_valid && (state_q == S_LOAD);
    assign pix_done = accept && (byte_cnt_q == 2'd2);
    assign last_pix = pix_done && (pix_idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_LOAD;
            S_LOAD: begin
                // abort outranks completion; a pixel finished this cycle is still written
                if (abort)         state_d = S_IDLE;
                else if (last_pix) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == S_LOAD);
        busy         = (state_q == S_LOAD);
        done         = (state_q == S_DONE);
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        pix_idx_d  = pix_idx_q;
        r_d        = r_q;
        g_d        = g_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (go) begin
            byte_cnt_d = 2'd0;
            pix_idx_d  = '0;
        end else if (accept) begin
            case (byte_cnt_q)
                2'd0: begin
                    r_d        = bus.in_byte;
                    byte_cnt_d = 2'd1;
                end
                2'd1: begin
                    g_d        = bus.in_byte;
                    byte_cnt_d = 2'd2;
                end
                default: begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = pix_idx_q;
                    wr_data_d  = {r_q, g_q, bus.in_byte};
                    byte_cnt_d = 2'd0;
                    // saturate so a full 2^ADDR_WIDTH image never wraps to 0
                    if (pix_idx_q != LAST_IDX) pix_idx_d = pix_idx_q + ADDR_WIDTH'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= 2'd0;
            pix_idx_q  <= '0;
            r_q        <= 8'd0;
            g_q        <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 24'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            pix_idx_q  <= pix_idx_d;
            r_q        <= r_d;
            g_q        <= g_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

`ifdef IMG_LOADER_CHKSUM_EN
    logic [23:0] chksum_q, chksum_d;

    // updated on the same edge as the write so the sum already includes the pixel on wr_en
    always_comb begin
        chksum_d = chksum_q;
        if (go)           chksum_d = 24'd0;
        else if (wr_en_d) chksum_d = chksum_q + wr_data_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chksum_q <= 24'd0;
        else        chksum_q <= chksum_d;
    end

    assign chksum = chksum_q;
`endif

endmodule
